n_bit_adder_reg: RTL and testbench

- Parameterised N-bit binary adder with carry-in and carry-out.
- Result is registered: one-cycle latency, valid-qualified.
- Used wherever a wide unsigned add must be timing-isolated.
- Default instance is 32 bits.
- Datapath is a chain of 4-bit carry-lookahead groups with ripple carry between groups.

---
 rtl/n_bit_adder_pkg.sv | 13 +
 rtl/n_bit_adder_reg_cla_group4.sv | 30 +++
 rtl/n_bit_adder_reg.sv | 104 ++++++++++
 tb/tb_n_bit_adder_reg.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/n_bit_adder_pkg.sv
// Shared constants and helpers for the registered N-bit adder.
// Optional overflow output is enabled by defining N_BIT_ADDER_OVF_EN.
package n_bit_adder_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int GROUP_WIDTH   = 4;

  // Number of 4-bit lookahead groups needed to cover an n-bit operand.
  function automatic int num_groups(input int n);
    return (n + GROUP_WIDTH - 1) / GROUP_WIDTH;
  endfunction

endpackage

// File: rtl/n_bit_adder_reg_cla_group4.sv
// 4-bit carry-lookahead slice. Purely combinational.
// c[i] is the carry into bit i (c[0] == ci); co is the carry out of bit 3.
module cla_group4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic [3:0] c
);

  logic [3:0] w_p;
  logic [3:0] w_g;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // Flattened lookahead equations; no carry ripples inside the group.
  assign c[0] = ci;
  assign c[1] = w_g[0] | (w_p[0] & ci);
  assign c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
  assign c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
              | (w_p[2] & w_p[1] & w_p[0] & ci);
  assign co   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
              | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);

  assign s = w_p ^ c;

endmodule

// File: rtl/n_bit_adder_reg.sv
// Registered N-bit unsigned adder: a + b + cin with one cycle of latency.
// Datapath is a ripple of 4-bit lookahead groups; the top group is
// zero-extended when N is not a multiple of 4.
// Define N_BIT_ADDER_OVF_EN to add a registered signed-overflow output ovf.
module n_bit_adder_reg
  import n_bit_adder_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  output logic [N-1:0] sum,
  output logic         cout
`ifdef N_BIT_ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int G = num_groups(N);
  localparam int W = G * GROUP_WIDTH;

  logic [W-1:0] w_a_ext;
  logic [W-1:0] w_b_ext;
  logic [W-1:0] w_sum_ext;
  logic [W:0]   w_carry;   // w_carry[i] = carry into bit i
  logic [G:0]   w_gc;      // inter-group ripple carries
  logic [N-1:0] w_sum_c;
  logic         w_cout_c;
  logic         w_unused;

  logic [N-1:0] r_sum;
  logic         r_cout;
  logic         r_valid;

  assign w_a_ext = W'(a);
  assign w_b_ext = W'(b);
  assign w_gc[0] = cin;

  for (genvar g = 0; g < G; g++) begin : g_grp
    cla_group4 u_cla (
      .a  (w_a_ext[GROUP_WIDTH*g +: GROUP_WIDTH]),
      .b  (w_b_ext[GROUP_WIDTH*g +: GROUP_WIDTH]),
      .ci (w_gc[g]),
      .s  (w_sum_ext[GROUP_WIDTH*g +: GROUP_WIDTH]),
      .co (w_gc[g+1]),
      .c  (w_carry[GROUP_WIDTH*g +: GROUP_WIDTH])
    );
  end

  assign w_carry[W] = w_gc[G];

  // The carry-out is the carry into bit N, which for a padded top group
  // sits inside the group rather than at its bit-4 carry.
  assign w_sum_c  = w_sum_ext[N-1:0];
  assign w_cout_c = w_carry[N];

  // Padding bits and internal carries that are not visible for this N.
  assign w_unused = ^{w_sum_ext, w_carry};

  // Capture result on valid input; hold otherwise, valid tracks input valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum  <= w_sum_c;
        r_cout <= w_cout_c;
      end
    end
  end

  assign out_valid = r_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;

`ifdef N_BIT_ADDER_OVF_EN
  logic w_ovf_c;
  logic r_ovf;

  // Signed overflow: carry into the MSB disagrees with carry out of it.
  assign w_ovf_c = w_carry[N-1] ^ w_carry[N];

  // Overflow flag registered with the same enable as the sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (in_valid) begin
      r_ovf <= w_ovf_c;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_n_bit_adder_reg.sv
// Self-checking bench for n_bit_adder_reg at N=1, N=5 and N=32.
module tb_n_bit_adder_reg;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst;

  logic        v1_i, c1_i, v1_o, co1, o1;
  logic [0:0]  a1, b1, s1;
  logic        v5_i, c5_i, v5_o, co5, o5;
  logic [4:0]  a5, b5, s5;
  logic        v32_i, c32_i, v32_o, co32, o32;
  logic [31:0] a32, b32, s32;

  exp_t q1[$];
  exp_t q5[$];
  exp_t q32[$];
  exp_t last1, last5, last32;

  int checks;
  int failures;

  n_bit_adder_reg #(.N(1)) u_n1 (
    .clk(clk), .rst(rst), .in_valid(v1_i), .a(a1), .b(b1), .cin(c1_i),
    .out_valid(v1_o), .sum(s1), .cout(co1)
`ifdef N_BIT_ADDER_OVF_EN
    , .ovf(o1)
`endif
  );

  n_bit_adder_reg #(.N(5)) u_n5 (
    .clk(clk), .rst(rst), .in_valid(v5_i), .a(a5), .b(b5), .cin(c5_i),
    .out_valid(v5_o), .sum(s5), .cout(co5)
`ifdef N_BIT_ADDER_OVF_EN
    , .ovf(o5)
`endif
  );

  n_bit_adder_reg #(.N(32)) u_n32 (
    .clk(clk), .rst(rst), .in_valid(v32_i), .a(a32), .b(b32), .cin(c32_i),
    .out_valid(v32_o), .sum(s32), .cout(co32)
`ifdef N_BIT_ADDER_OVF_EN
    , .ovf(o32)
`endif
  );

`ifndef N_BIT_ADDER_OVF_EN
  assign o1  = 1'b0;
  assign o5  = 1'b0;
  assign o32 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic exp_t calc(input int n, input logic [63:0] a,
                                input logic [63:0] b, input logic c);
    logic [64:0] full;
    logic [63:0] mask;
    exp_t e;
    mask   = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    full   = {1'b0, a & mask} + {1'b0, b & mask} + 65'(c);
    e.sum  = full[63:0] & mask;
    e.cout = full[n];
    e.ovf  = (a[n-1] == b[n-1]) && (e.sum[n-1] != a[n-1]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(input string nm, input logic ov, input logic [63:0] os,
                         input logic oc, input logic oo, input bit have,
                         input exp_t e, input exp_t last);
    chk($sformatf("%s out_valid", nm), 64'(ov), 64'(have));
    if (have) begin
      chk($sformatf("%s sum", nm), os, e.sum);
      chk($sformatf("%s cout", nm), 64'(oc), 64'(e.cout));
`ifdef N_BIT_ADDER_OVF_EN
      chk($sformatf("%s ovf", nm), 64'(oo), 64'(e.ovf));
`endif
    end else begin
      chk($sformatf("%s hold sum", nm), os, last.sum);
      chk($sformatf("%s hold cout", nm), 64'(oc), 64'(last.cout));
`ifdef N_BIT_ADDER_OVF_EN
      chk($sformatf("%s hold ovf", nm), 64'(oo), 64'(last.ovf));
`endif
    end
  endtask

  // One clock: let the DUTs capture, then compare outputs against the scoreboard.
  task automatic tick();
    bit   have;
    exp_t e;
    @(posedge clk);
    #1;
    have = (q32.size() != 0);
    e = '0;
    if (have) e = q32.pop_front();
    chk_dut("n32", v32_o, 64'(s32), co32, o32, have, e, last32);
    if (have) last32 = e;
    have = (q5.size() != 0);
    e = '0;
    if (have) e = q5.pop_front();
    chk_dut("n5", v5_o, 64'(s5), co5, o5, have, e, last5);
    if (have) last5 = e;
    have = (q1.size() != 0);
    e = '0;
    if (have) e = q1.pop_front();
    chk_dut("n1", v1_o, 64'(s1), co1, o1, have, e, last1);
    if (have) last1 = e;
    v1_i  = 1'b0;
    v5_i  = 1'b0;
    v32_i = 1'b0;
  endtask

  task automatic drive32(input logic [31:0] a, input logic [31:0] b, input logic c);
    v32_i = 1'b1; a32 = a; b32 = b; c32_i = c;
    if (!rst) q32.push_back(calc(32, 64'(a), 64'(b), c));
  endtask

  task automatic drive5(input logic [4:0] a, input logic [4:0] b, input logic c);
    v5_i = 1'b1; a5 = a; b5 = b; c5_i = c;
    if (!rst) q5.push_back(calc(5, 64'(a), 64'(b), c));
  endtask

  task automatic drive1(input logic [0:0] a, input logic [0:0] b, input logic c);
    v1_i = 1'b1; a1 = a; b1 = b; c1_i = c;
    if (!rst) q1.push_back(calc(1, 64'(a), 64'(b), c));
  endtask

  logic [31:0] corners [5];

  initial begin
    checks = 0; failures = 0;
    last1 = '0; last5 = '0; last32 = '0;
    rst = 1'b1;
    v1_i = 0; a1 = 0; b1 = 0; c1_i = 0;
    v5_i = 0; a5 = 0; b5 = 0; c5_i = 0;
    v32_i = 0; a32 = 0; b32 = 0; c32_i = 0;
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'h7FFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'hFFFF_FFFF;

    // Reset state.
    tick();
    tick();

    // Operand presented while rst is high is not captured.
    drive32(32'd9, 32'd9, 1'b0);
    tick();

    // First edge with rst low captures: 3 + 4 + 1 = 8.
    rst = 1'b0;
    drive32(32'h3, 32'h4, 1'b1);
    tick();
    chk("basic sum", 64'(s32), 64'h8);

    // Wrap-around cases.
    drive32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    tick();
    drive32(32'hFFFF_FFFF, 32'h0, 1'b1);
    tick();
    chk("wrap zero cout", 64'(co32), 64'h1);

    // Back-to-back throughput, then hold with X operands.
    drive32(32'd1, 32'd1, 1'b0);
    tick();
    drive32(32'd2, 32'd2, 1'b0);
    tick();
    drive32(32'd3, 32'd3, 1'b1);
    tick();
    v32_i = 1'b0; a32 = 'x; b32 = 'x; c32_i = 'x;
    tick();
    chk("hold sum after x", 64'(s32), 64'd7);
    tick();

    // Asynchronous reset mid-cycle discards the in-flight operand.
    drive32(32'd10, 32'd20, 1'b0);
    tick();
    v32_i = 1'b1; a32 = 32'd5; b32 = 32'd7; c32_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async rst sum", 64'(s32), 64'h0);
    chk("async rst cout", 64'(co32), 64'h0);
    chk("async rst valid", 64'(v32_o), 64'h0);
    q1.delete(); q5.delete(); q32.delete();
    last1 = '0; last5 = '0; last32 = '0;
    tick();
    rst = 1'b0;
    drive32(32'd5, 32'd7, 1'b0);
    tick();

    // Exhaustive N=1 and N=5.
    for (int i = 0; i < 8; i++) begin
      drive1(i[2:2], i[1:1], i[0]);
      tick();
    end
    for (int i = 0; i < 2048; i++) begin
      drive5(i[10:6], i[5:1], i[0]);
      tick();
    end

    // N=32 corner pairs.
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        for (int c = 0; c < 2; c++) begin
          drive32(corners[i], corners[j], c[0]);
          tick();
        end

    // N=32 random vectors, with back-to-back bursts and idle gaps mixed in.
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) != 0) drive32($urandom(), $urandom(), 1'($urandom_range(0, 1)));
      tick();
    end

`ifdef N_BIT_ADDER_OVF_EN
    drive32(32'h7FFF_FFFF, 32'h1, 1'b0);
    tick();
    chk("ovf max+1", 64'(o32), 64'h1);
    drive32(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    tick();
    chk("ovf min-1", 64'(o32), 64'h1);
    chk("ovf min-1 cout", 64'(co32), 64'h1);
    drive32(32'hFFFF_FFFF, 32'h1, 1'b0);
    tick();
    chk("ovf -1+1", 64'(o32), 64'h0);
    chk("ovf -1+1 cout", 64'(co32), 64'h1);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
